// File: rtl/proc_pkg.sv
// Shared definitions for the processor front end: fetch FSM states and the
// opcodes the fetch controller has to recognise.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPERAND,
    JUMP,
    ISSUE,
    HALT
  } state_t;

  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_BRZ = 3'b101;
  localparam logic [2:0] OP_HLT = 3'b111;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: fetches opcode bytes, resolves JMP/BRZ/HLT
// locally and hands every other opcode to the execute stage.
module fetch_ctrl
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pc_addr,
  input  logic       zero_flag,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       inc_pc,
  output logic       load_pc,
  output logic [7:0] pc_in,
  output logic [7:0] ir,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic       halt
);

  state_t     state, state_nxt;
  logic [7:0] ir_q;
  logic [7:0] target;

  assign ir = ir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ir_q   <= 8'h00;
      target <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem_ack)
        ir_q <= mem_rdata;
      if (state == OPERAND && mem_ack)
        target <= mem_rdata;
    end
  end

  // All outputs decode from state, so reset clears them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = 8'h00;
    inc_pc    = 1'b0;
    load_pc   = 1'b0;
    pc_in     = 8'h00;
    ir_valid  = 1'b0;
    halt      = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_addr;
        if (mem_ack) begin
          inc_pc    = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        case (ir_q[7:5])
          OP_JMP: state_nxt = OPERAND;
          OP_BRZ: begin
            if (zero_flag) begin
              state_nxt = OPERAND;
            end else begin
              // branch not taken: step over the operand byte
              inc_pc    = 1'b1;
              state_nxt = FETCH;
            end
          end
          OP_HLT:  state_nxt = HALT;
          default: state_nxt = ISSUE;
        endcase
      end
      OPERAND: begin
        mem_req  = 1'b1;
        mem_addr = pc_addr;
        if (mem_ack)
          state_nxt = JUMP;
      end
      JUMP: begin
        load_pc   = 1'b1;
        pc_in     = target;
        state_nxt = FETCH;
      end
      ISSUE: begin
        ir_valid = 1'b1;
        if (ir_ready)
          state_nxt = FETCH;
      end
      HALT:    halt = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: memory + PC model, vector table with a
// scoreboard of issued instructions / jump targets, plus corner sequences.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc;
  logic [7:0] pc_set_val = 8'h00;
  logic       pc_set = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_req, mem_ack;
  logic [7:0] mem_addr, mem_rdata;
  logic       inc_pc, load_pc;
  logic [7:0] pc_in, ir;
  logic       ir_valid, halt;
  logic       ir_ready = 1'b1;
  logic       stray_ack = 1'b0;
  int         ack_delay = 0;
  int         wait_cnt = 0;
  logic [7:0] mem [256];

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] exp_ir_q[$];
  logic [7:0] exp_tgt_q[$];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_addr(pc), .zero_flag(zero_flag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inc_pc(inc_pc), .load_pc(load_pc), .pc_in(pc_in),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .halt(halt)
  );

  // Memory answers combinationally once the request has waited ack_delay cycles.
  assign mem_ack   = stray_ack || (mem_req && wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk)
    wait_cnt <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;

  always @(posedge clk) begin
    if (pc_set)       pc <= pc_set_val;
    else if (inc_pc)  pc <= pc + 8'd1;
    else if (load_pc) pc <= pc_in;
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       zf;
    int         nreq;
    int         inc;
    int         ld;
    int         iss;
    logic [7:0] nxt;
    int         lat;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({mem_req, inc_pc, load_pc, ir_valid, halt, pc_in, ir});
  endfunction

  task automatic do_reset(input logic [7:0] start);
    reset = 1'b1;
    pc_set_val = start;
    pc_set = 1'b1;
    @(posedge clk);
    #1 pc_set = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // which: 0 mem_req, 1 ir_valid, 2 halt
  task automatic wait_for(input int which, input string name);
    logic s;
    s = 1'b0;
    for (int c = 0; c < 20 && !s; c++) begin
      @(negedge clk);
      case (which)
        0:       s = mem_req;
        1:       s = ir_valid;
        default: s = halt;
      endcase
    end
    if (!s) chk(name, int'(s), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int inc, ld, both, rises, fcyc, ecyc;
    logic prev, done;
    logic [7:0] a1;
    a1 = v.addr + 8'd1;
    ir_ready = 1'b1;
    zero_flag = v.zf;
    ack_delay = 0;
    mem[v.addr] = v.b0;
    mem[a1] = v.b1;
    if (v.ld != 0) exp_tgt_q.push_back(v.b1);
    if (v.iss != 0) exp_ir_q.push_back(v.b0);
    do_reset(v.addr);
    inc = 0; ld = 0; both = 0; rises = 0; fcyc = -1; ecyc = -1;
    prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        rises++;
        if (rises == 1) fcyc = c;
      end
      prev = mem_req;
      if (rises == v.nreq) begin
        chk("next_addr", int'(mem_addr), int'(v.nxt));
        done = 1'b1;
      end else begin
        if (inc_pc) inc++;
        if (load_pc) ld++;
        if (inc_pc && load_pc) both++;
        if (load_pc) begin
          ecyc = c;
          if (exp_tgt_q.size() > 0) chk("pc_in", int'(pc_in), int'(exp_tgt_q.pop_front()));
          else chk("unexpected_load", int'(load_pc), 0);
        end
        if (ir_valid && ir_ready) begin
          ecyc = c;
          if (exp_ir_q.size() > 0) chk("ir", int'(ir), int'(exp_ir_q.pop_front()));
          else chk("unexpected_issue", int'(ir_valid), 0);
        end
      end
    end
    if (!done) chk("next_fetch_timeout", rises, v.nreq);
    chk("inc_count", inc, v.inc);
    chk("load_count", ld, v.ld);
    chk("inc_and_load", both, 0);
    if (v.lat >= 0) chk("latency", ecyc - fcyc, v.lat);
  endtask

  initial begin
    int cnt, inc_bad, incs, addr_bad;

    //        addr   b0     b1     zf nreq inc ld iss nxt   lat
    vt[0]  = '{8'h00, 8'h21, 8'h00, 0, 2, 1, 0, 1, 8'h01, 2};
    vt[1]  = '{8'h05, 8'hC0, 8'h40, 0, 3, 1, 1, 0, 8'h40, 3};
    vt[2]  = '{8'h10, 8'hA0, 8'h77, 0, 2, 2, 0, 0, 8'h12, -1};
    vt[3]  = '{8'h10, 8'hA0, 8'h77, 1, 3, 1, 1, 0, 8'h77, 3};
    vt[4]  = '{8'hFF, 8'hC5, 8'h9A, 0, 3, 1, 1, 0, 8'h9A, 3};
    vt[5]  = '{8'h80, 8'h1F, 8'h00, 1, 2, 1, 0, 1, 8'h81, 2};
    vt[6]  = '{8'h40, 8'h3C, 8'h00, 0, 2, 1, 0, 1, 8'h41, 2};
    vt[7]  = '{8'h90, 8'h5A, 8'h00, 1, 2, 1, 0, 1, 8'h91, 2};
    vt[8]  = '{8'hC8, 8'h9E, 8'h00, 0, 2, 1, 0, 1, 8'hC9, 2};
    vt[9]  = '{8'h7F, 8'h6B, 8'h00, 0, 2, 1, 0, 1, 8'h80, 2};
    vt[10] = '{8'h20, 8'hDF, 8'h08, 1, 3, 1, 1, 0, 8'h08, 3};

    // reset state
    #1 chk("reset_outputs", outs(), 0);

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // 3-cycle memory wait: request and address held, single inc on the ack cycle
    ack_delay = 3; ir_ready = 1'b1;
    mem[8'h20] = 8'h21;
    do_reset(8'h20);
    wait_for(0, "wait_req_delay");
    cnt = 0; inc_bad = 0; incs = 0; addr_bad = 0;
    for (int c = 0; c < 10 && mem_req; c++) begin
      cnt++;
      if (mem_addr != 8'h20) addr_bad++;
      if (inc_pc) incs++;
      if (inc_pc != mem_ack) inc_bad++;
      @(negedge clk);
    end
    chk("delay_req_cycles", cnt, 4);
    chk("delay_addr_stable", addr_bad, 0);
    chk("delay_inc_count", incs, 1);
    chk("delay_inc_only_on_ack", inc_bad, 0);
    ack_delay = 0;

    // execute stage stalls for 5 cycles
    ir_ready = 1'b0;
    mem[8'h30] = 8'h45;
    do_reset(8'h30);
    wait_for(1, "wait_issue_stall");
    for (int c = 0; c < 5; c++) begin
      chk("stall_ir_valid", int'(ir_valid), 1);
      chk("stall_ir", int'(ir), 8'h45);
      chk("stall_mem_req", int'(mem_req), 0);
      @(negedge clk);
    end
    ir_ready = 1'b1;
    #1 chk("ready_no_comb_req", int'(mem_req), 0);
    @(negedge clk);
    chk("resume_req", int'(mem_req), 1);
    chk("resume_addr", int'(mem_addr), 8'h31);

    // halt persists
    mem[8'h50] = 8'hE0;
    do_reset(8'h50);
    wait_for(2, "wait_halt");
    for (int c = 0; c < 20; c++) begin
      chk("halt_held", int'(halt), 1);
      chk("halt_no_req", int'(mem_req), 0);
      @(negedge clk);
    end

    // reset in the middle of a stalled fetch, then stray ack while idle
    ack_delay = 5;
    mem[8'h60] = 8'h21;
    do_reset(8'h60);
    wait_for(0, "wait_req_midreset");
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", outs(), 0);
    stray_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stray_ack_ignored", outs(), 0);
    stray_ack = 1'b0;
    ack_delay = 0;
    mem[8'h70] = 8'h21;
    do_reset(8'h70);
    wait_for(0, "wait_req_after_reset");
    chk("first_fetch_addr", int'(mem_addr), 8'h70);
    wait_for(1, "wait_issue_after_reset");
    chk("first_issue_ir", int'(ir), 8'h21);

    chk("scoreboard_empty", exp_ir_q.size() + exp_tgt_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
